// File: rtl/swin_conf_decoder.sv
// Config-driven sliding-window writer: fetches entries from config BRAM and
// scatters incoming pixel beats into rotating line-buffer bank rows.
module swin_conf_decoder #(
   parameter int PIX_W       = 8,
   parameter int LANES       = 8,
   parameter int BANKS       = 3,
   parameter int CYC_W       = 8,
   parameter int CONF_ADDR_W = 9,
   parameter int CONF_BRAM_W = 72
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           dec_en,
   input  logic                           restart,
   output logic [CONF_ADDR_W-1:0]         conf_bram_rd_addr,
   input  logic [CONF_BRAM_W-1:0]         conf_bram_rd_data,
   input  logic                           pix_in_vld,
   input  logic [LANES*PIX_W-1:0]         pix_in_data,
   output logic                           pix_in_rdy,
   output logic [BANKS*2*LANES*PIX_W-1:0] wr_data,
   output logic [BANKS*2*LANES-1:0]       wr_data_mask,
   output logic [BANKS-1:0]               wr_data_en,
   output logic                           entry_done,
   output logic                           frame_done
);
   localparam int OFS_W  = $clog2(LANES);
   localparam int ROW_W  = 2*LANES*PIX_W;
   localparam int SLOT_W = 2*LANES;
   localparam int FLD_W  = OFS_W + BANKS + CYC_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_RUN   = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [CONF_ADDR_W-1:0] addr_q, addr_d;
   logic [CYC_W-1:0]       cnt_q, cnt_d;
   logic [OFS_W-1:0]       ofs_q, ofs_d;
   logic [BANKS-1:0]       sel_q, sel_d;
   logic                   ret_q, ret_d;

   logic [BANKS*ROW_W-1:0]  wr_data_q, wr_data_d;
   logic [BANKS*SLOT_W-1:0] wr_mask_q, wr_mask_d;
   logic [BANKS-1:0]        wr_en_q, wr_en_d;
   logic                    entry_done_q, entry_done_d;
   logic                    frame_done_q, frame_done_d;

   logic [OFS_W-1:0] c_ofs;
   logic [BANKS-1:0] c_ord;
   logic [CYC_W-1:0] c_cyc;
   logic             c_ret;
   logic             unused_conf_hi;

   assign c_ofs = conf_bram_rd_data[OFS_W-1:0];
   assign c_ord = conf_bram_rd_data[OFS_W +: BANKS];
   assign c_cyc = conf_bram_rd_data[OFS_W+BANKS +: CYC_W];
   assign c_ret = conf_bram_rd_data[OFS_W+BANKS+CYC_W];
   assign unused_conf_hi = ^conf_bram_rd_data[CONF_BRAM_W-1:FLD_W];

   logic xfer, last, out_vld;
   logic [ROW_W-1:0]  row;
   logic [SLOT_W-1:0] mrow;

   assign pix_in_rdy = (state_q == S_RUN);
   assign xfer       = pix_in_vld & pix_in_rdy;
   assign last       = xfer & (cnt_q == '0);
   // a restart in the same cycle cancels the write side-effects of that beat
   assign out_vld    = xfer & ~restart;
   assign row        = ROW_W'(pix_in_data) << (ofs_q * PIX_W);
   assign mrow       = SLOT_W'({LANES{1'b1}}) << ofs_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      ofs_d   = ofs_q;
      sel_d   = sel_q;
      ret_d   = ret_q;
      case (state_q)
         S_IDLE:  if (dec_en) state_d = S_FETCH;
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            ofs_d   = c_ofs;
            sel_d   = (c_ord == '0) ? BANKS'(1) : c_ord;
            cnt_d   = c_cyc;
            ret_d   = c_ret;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (last) begin
               addr_d  = ret_q ? '0 : addr_q + CONF_ADDR_W'(1);
               state_d = dec_en ? S_FETCH : S_IDLE;
            end else if (xfer) begin
               cnt_d = cnt_q - CYC_W'(1);
               sel_d = {sel_q[0], sel_q[BANKS-1:1]};
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (restart) begin
         addr_d  = '0;
         cnt_d   = '0;
         sel_d   = '0;
         state_d = dec_en ? S_FETCH : S_IDLE;
      end
   end

   always_comb begin
      wr_data_d = '0;
      wr_mask_d = '0;
      wr_en_d   = '0;
      for (int b = 0; b < BANKS; b++) begin
         if (out_vld && sel_q[b]) begin
            wr_data_d[b*ROW_W +: ROW_W]   = row;
            wr_mask_d[b*SLOT_W +: SLOT_W] = mrow;
            wr_en_d[b]                    = 1'b1;
         end
      end
      entry_done_d = last & ~restart;
      frame_done_d = last & ~restart & ret_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         cnt_q        <= '0;
         ofs_q        <= '0;
         sel_q        <= '0;
         ret_q        <= 1'b0;
         wr_data_q    <= '0;
         wr_mask_q    <= '0;
         wr_en_q      <= '0;
         entry_done_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         ofs_q        <= ofs_d;
         sel_q        <= sel_d;
         ret_q        <= ret_d;
         wr_data_q    <= wr_data_d;
         wr_mask_q    <= wr_mask_d;
         wr_en_q      <= wr_en_d;
         entry_done_q <= entry_done_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign conf_bram_rd_addr = addr_q;
   assign wr_data           = wr_data_q;
   assign wr_data_mask      = wr_mask_q;
   assign wr_data_en        = wr_en_q;
   assign entry_done        = entry_done_q;
   assign frame_done        = frame_done_q;
endmodule

// File: tb/tb_swin_conf_decoder.sv
// Scoreboard bench: expected writes are queued as beats are driven and
// compared on the cycle the decoder should present them.
module tb_swin_conf_decoder;
   localparam int PIX_W = 8, LANES = 8, BANKS = 3, CYC_W = 8;
   localparam int AW = 9, CW = 72;
   localparam int ROW_W = 2*LANES*PIX_W;
   localparam int DW = BANKS*ROW_W;
   localparam int MW = BANKS*2*LANES;

   logic clk, rst, dec_en, restart;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] rd_data;
   logic pix_in_vld, pix_in_rdy;
   logic [LANES*PIX_W-1:0] pix_in_data;
   logic [DW-1:0] wr_data;
   logic [MW-1:0] wr_data_mask;
   logic [BANKS-1:0] wr_data_en;
   logic entry_done, frame_done;

   swin_conf_decoder dut (
      .clk(clk), .rst(rst), .dec_en(dec_en), .restart(restart),
      .conf_bram_rd_addr(rd_addr), .conf_bram_rd_data(rd_data),
      .pix_in_vld(pix_in_vld), .pix_in_data(pix_in_data), .pix_in_rdy(pix_in_rdy),
      .wr_data(wr_data), .wr_data_mask(wr_data_mask), .wr_data_en(wr_data_en),
      .entry_done(entry_done), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [CW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) rd_data <= mem[rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int               due;
      logic [DW-1:0]    d;
      logic [MW-1:0]    m;
      logic [BANKS-1:0] en;
      logic             ed, fd;
   } exp_t;
   exp_t sb[$];

   int n_chk = 0, n_fail = 0;
   logic mon_on = 1'b0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         while (sb.size() > 0 && sb[0].due < cyc) begin
            void'(sb.pop_front());
            chk("missed_write", 1, 0);
         end
         if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("wr_data", wr_data, e.d);
            chk("wr_mask", DW'(wr_data_mask), DW'(e.m));
            chk("wr_en", DW'(wr_data_en), DW'(e.en));
            chk("entry_done", DW'(entry_done), DW'(e.ed));
            chk("frame_done", DW'(frame_done), DW'(e.fd));
         end else begin
            chk("idle_en", DW'(wr_data_en), '0);
            chk("idle_data", wr_data, '0);
            chk("idle_mask", DW'(wr_data_mask), '0);
            chk("idle_done", DW'({entry_done, frame_done}), '0);
         end
      end
   end

   // Bench-side model of the entry currently being streamed
   int m_ofs, m_left;
   logic [BANKS-1:0] m_sel;
   logic m_ret;

   function automatic logic [CW-1:0] pack(input int ofs, input logic [2:0] ord,
                                          input int cy, input logic ret);
      logic [CW-1:0] w;
      w = '0;
      w[2:0]  = 3'(ofs);
      w[5:3]  = ord;
      w[13:6] = 8'(cy);
      w[14]   = ret;
      return w;
   endfunction

   task automatic start_entry(input int ofs, input logic [2:0] ord, input int cy, input logic ret);
      int n;
      m_ofs  = ofs;
      m_sel  = (ord == 3'b000) ? 3'b001 : ord;
      m_left = cy + 1;
      m_ret  = ret;
      n = 0;
      while (!pix_in_rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rdy_wait", DW'(pix_in_rdy), DW'(1));
   endtask

   task automatic send(input logic v, input logic rs, input logic rr);
      exp_t e;
      logic [LANES*PIX_W-1:0] p;
      p = {$urandom, $urandom};
      pix_in_data = p;
      pix_in_vld  = v;
      restart     = rs;
      rst         = rr;
      if (v && pix_in_rdy && !rs && !rr) begin
         e.due = cyc + 1;
         e.d = '0;
         e.m = '0;
         e.en = m_sel;
         for (int b = 0; b < BANKS; b++)
            if (m_sel[b])
               for (int l = 0; l < LANES; l++) begin
                  e.d[b*ROW_W + (l+m_ofs)*PIX_W +: PIX_W] = p[l*PIX_W +: PIX_W];
                  e.m[b*2*LANES + l + m_ofs] = 1'b1;
               end
         e.ed = (m_left == 1);
         e.fd = e.ed & m_ret;
         sb.push_back(e);
         m_left--;
         m_sel = {m_sel[0], m_sel[BANKS-1:1]};
      end
      @(negedge clk);
      pix_in_vld = 1'b0;
      restart    = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; dec_en = 1'b0; restart = 1'b0;
      pix_in_vld = 1'b0; pix_in_data = '0;
      for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
      mem[0] = pack(3, 3'b001, 2, 1'b0);
      mem[1] = pack(0, 3'b000, 1, 1'b0);
      mem[2] = pack(7, 3'b101, 3, 1'b0);
      mem[3] = pack(1, 3'b010, 0, 1'b0);
      mem[4] = pack(2, 3'b100, 4, 1'b0);
      mem[5] = pack(5, 3'b011, 0, 1'b1);
      repeat (3) @(negedge clk);
      mon_on = 1'b1;
      chk("rst_addr", DW'(rd_addr), '0);
      chk("rst_rdy", DW'(pix_in_rdy), '0);
      rst = 1'b0;
      dec_en = 1'b1;

      // offset 3, bank0 start, 3 beats; address advances to 1
      start_entry(3, 3'b001, 2, 1'b0);
      chk("e0_addr", DW'(rd_addr), DW'(0));
      repeat (3) send(1, 0, 0);
      chk("e0_addr_next", DW'(rd_addr), DW'(1));
      chk("e0_gap_rdy", DW'(pix_in_rdy), '0);

      // order 0 falls back to bank 0
      start_entry(0, 3'b000, 1, 1'b0);
      repeat (2) send(1, 0, 0);

      // broadcast order with vld toggling: rdy holds through bubbles
      start_entry(7, 3'b101, 3, 1'b0);
      for (int i = 0; i < 7; i++) begin
         chk("vld_gap_rdy", DW'(pix_in_rdy), DW'(1));
         send((i % 2) == 0, 0, 0);
      end
      chk("e2_done_rdy", DW'(pix_in_rdy), '0);

      start_entry(1, 3'b010, 0, 1'b0);
      send(1, 0, 0);

      // dec_en dropped after first beat: entry completes then parks
      start_entry(2, 3'b100, 4, 1'b0);
      send(1, 0, 0);
      dec_en = 1'b0;
      repeat (4) send(1, 0, 0);
      repeat (3) begin
         chk("park_rdy", DW'(pix_in_rdy), '0);
         chk("park_addr", DW'(rd_addr), DW'(5));
         @(negedge clk);
      end
      dec_en = 1'b1;

      // ret=1 single-beat entry: both done pulses, address back to 0
      start_entry(5, 3'b011, 0, 1'b1);
      chk("ret_addr", DW'(rd_addr), DW'(5));
      dec_en = 1'b0;
      send(1, 0, 0);
      chk("ret_addr_next", DW'(rd_addr), '0);

      for (int i = 0; i < 6; i++) mem[i] = pack(i, 3'((i % 7) + 1), 0, 1'b0);
      mem[6] = pack(2, 3'b010, 255, 1'b0);
      mem[7] = pack(6, 3'b001, 1, 1'b0);
      dec_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         start_entry(i, 3'((i % 7) + 1), 0, 1'b0);
         send(1, 0, 0);
      end
      start_entry(2, 3'b010, 255, 1'b0);
      repeat (256) send(1, 0, 0);
      chk("long_addr", DW'(rd_addr), DW'(7));

      // restart on the last beat of addr 7: no write, restart at 0
      start_entry(6, 3'b001, 1, 1'b0);
      send(1, 0, 0);
      send(1, 1, 0);
      chk("rs_addr", DW'(rd_addr), '0);
      chk("rs_rdy", DW'(pix_in_rdy), '0);
      mem[1] = pack(4, 3'b110, 5, 1'b0);
      start_entry(0, 3'b001, 0, 1'b0);
      chk("rs_fetch_addr", DW'(rd_addr), '0);
      send(1, 0, 0);

      // reset mid-entry discards the entry
      start_entry(4, 3'b110, 5, 1'b0);
      repeat (2) send(1, 0, 0);
      send(1, 0, 1);
      chk("mr_addr", DW'(rd_addr), '0);
      chk("mr_rdy", DW'(pix_in_rdy), '0);
      chk("mr_en", DW'(wr_data_en), '0);
      chk("mr_done", DW'({entry_done, frame_done}), '0);
      dec_en = 1'b0;
      rst = 1'b0;
      repeat (3) begin
         chk("post_rst_idle", DW'(pix_in_rdy), '0);
         @(negedge clk);
      end

      chk("sb_empty", DW'(sb.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
